decode_stage: RTL and testbench

Y86-64 pipeline decode stage. Holds the D pipeline register fed by the fetch stage's 145-bit D bundle, the 15-entry register file written from write-back, and the forwarding network. Produces the 217-bit E bundle for the execute stage plus source IDs for the hazard unit.

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/y86_regfile.sv | 47 ++++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 decode-stage shared constants
// Purpose: icode values, special register IDs, D/E bundle field offsets and
//          the bubble values loaded into the D and E pipeline registers.
// Ports:   none (package).
package y86_pkg;

  // Instruction codes that the decode selection cares about.
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  // D bundle: stat, icode, ifun, rA, rB, valC, valP
  localparam int D_W     = 145;
  localparam int D_STAT  = 144;
  localparam int D_ICODE = 140;
  localparam int D_IFUN  = 136;
  localparam int D_RA    = 132;
  localparam int D_RB    = 128;
  localparam int D_VALC  = 64;
  localparam int D_VALP  = 0;

  // E bundle: stat, icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB
  localparam int E_W     = 217;
  localparam int E_STAT  = 216;
  localparam int E_ICODE = 212;
  localparam int E_IFUN  = 208;
  localparam int E_VALC  = 144;
  localparam int E_VALA  = 80;
  localparam int E_VALB  = 16;
  localparam int E_DSTE  = 12;
  localparam int E_DSTM  = 8;
  localparam int E_SRCA  = 4;
  localparam int E_SRCB  = 0;

  localparam logic [D_W-1:0] D_BUBBLE =
    {1'b1, I_NOP, 4'h0, RNONE, RNONE, 64'd0, 64'd0};

  localparam logic [E_W-1:0] E_BUBBLE =
    {1'b1, I_NOP, 4'h0, 64'd0, 64'd0, 64'd0, RNONE, RNONE, RNONE, RNONE};

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - Y86-64 register file, two write and two read ports
// Purpose: NREG x W storage written at the rising edge, read combinationally.
// Ports:   clk_i, rst_ni        clock, async active-low reset (clears all)
//          e_addr_i/e_data_i    write port E (ID 15 or above ignored)
//          m_addr_i/m_data_i    write port M, wins over E on same ID
//          ra_addr_i/ra_data_o  read port A (out-of-range ID reads 0)
//          rb_addr_i/rb_data_o  read port B (out-of-range ID reads 0)
module y86_regfile #(
  parameter int NREG = 15,
  parameter int W    = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [3:0]   e_addr_i,
  input  logic [W-1:0] e_data_i,
  input  logic [3:0]   m_addr_i,
  input  logic [W-1:0] m_data_i,
  input  logic [3:0]   ra_addr_i,
  output logic [W-1:0] ra_data_o,
  input  logic [3:0]   rb_addr_i,
  output logic [W-1:0] rb_data_o
);

  logic [W-1:0] regs_q [NREG];

  // Address RNONE matches no entry, so writes to it fall away naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (m_addr_i == 4'(i))      regs_q[i] <= m_data_i;
        else if (e_addr_i == 4'(i)) regs_q[i] <= e_data_i;
      end
    end
  end

  always_comb begin
    ra_data_o = '0;
    rb_data_o = '0;
    for (int i = 0; i < NREG; i++) begin
      if (ra_addr_i == 4'(i)) ra_data_o = regs_q[i];
      if (rb_addr_i == 4'(i)) rb_data_o = regs_q[i];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Y86-64 pipeline decode stage
// Purpose: D pipeline register, source/destination selection, forwarding,
//          register file and the E pipeline register.
// Ports:   clk, rst_n                       clock, async active-low reset
//          f_d                              145-bit fetch bundle
//          D_stall, D_bubble, E_bubble      hazard-unit controls
//          e_dstE/e_valE                    execute-stage forwarding source
//          M_dstE/M_valE, M_dstM/m_valM     memory-stage forwarding sources
//          W_dstE/W_valE, W_dstM/W_valM     write-back forward + regfile writes
//          d_srcA, d_srcB                   source IDs from the D register
//          e_bundle                         217-bit E register
module decode_stage
  import y86_pkg::*;
#(
  parameter int NREG = 15,
  parameter int W    = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [D_W-1:0] f_d,
  input  logic           D_stall,
  input  logic           D_bubble,
  input  logic           E_bubble,
  input  logic [3:0]     e_dstE,
  input  logic [W-1:0]   e_valE,
  input  logic [3:0]     M_dstE,
  input  logic [W-1:0]   M_valE,
  input  logic [3:0]     M_dstM,
  input  logic [W-1:0]   m_valM,
  input  logic [3:0]     W_dstE,
  input  logic [W-1:0]   W_valE,
  input  logic [3:0]     W_dstM,
  input  logic [W-1:0]   W_valM,
  output logic [3:0]     d_srcA,
  output logic [3:0]     d_srcB,
  output logic [E_W-1:0] e_bundle
);

  logic [D_W-1:0] d_q, d_d;
  logic [E_W-1:0] e_q, e_d;

  logic [3:0]   icode, r_a, r_b;
  logic [3:0]   src_a, src_b, dst_e, dst_m;
  logic [W-1:0] rf_a, rf_b, fwd_a, fwd_b, val_a;

  assign icode = d_q[D_ICODE +: 4];
  assign r_a   = d_q[D_RA +: 4];
  assign r_b   = d_q[D_RB +: 4];

  // Stall outranks bubble when the hazard unit asserts both.
  always_comb begin
    d_d = d_q;
    if (!D_stall) d_d = D_bubble ? D_BUBBLE : f_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= D_BUBBLE;
    else        d_q <= d_d;
  end

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      I_RRMOVQ: begin src_a = r_a; dst_e = r_b; end
      I_IRMOVQ: dst_e = r_b;
      I_RMMOVQ: begin src_a = r_a; src_b = r_b; end
      I_MRMOVQ: begin src_b = r_b; dst_m = r_a; end
      I_OPQ:    begin src_a = r_a; src_b = r_b; dst_e = r_b; end
      I_CALL:   begin src_b = RRSP; dst_e = RRSP; end
      I_RET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      I_PUSHQ:  begin src_a = r_a; src_b = RRSP; dst_e = RRSP; end
      I_POPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = r_a; end
      default:  ;
    endcase
  end

  assign d_srcA = src_a;
  assign d_srcB = src_b;

  y86_regfile #(.NREG(NREG), .W(W)) u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .e_addr_i  (W_dstE),
    .e_data_i  (W_valE),
    .m_addr_i  (W_dstM),
    .m_data_i  (W_valM),
    .ra_addr_i (src_a),
    .ra_data_o (rf_a),
    .rb_addr_i (src_b),
    .rb_data_o (rf_b)
  );

  // Youngest producer first; a W hit covers the array write that has not
  // committed yet. RNONE never matches and reads 0.
  function automatic logic [W-1:0] fwd(input logic [3:0] src, input logic [W-1:0] rf_val);
    if (src == RNONE)       return '0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_val;
  endfunction

  assign fwd_a = fwd(src_a, rf_a);
  assign fwd_b = fwd(src_b, rf_b);

  // jXX and call carry the return/fall-through address in valA.
  assign val_a = (icode == I_JXX || icode == I_CALL) ? d_q[D_VALP +: 64] : fwd_a;

  always_comb begin
    e_d = E_BUBBLE;
    if (!E_bubble) begin
      e_d[E_STAT]         = d_q[D_STAT];
      e_d[E_ICODE +: 4]   = icode;
      e_d[E_IFUN +: 4]    = d_q[D_IFUN +: 4];
      e_d[E_VALC +: 64]   = d_q[D_VALC +: 64];
      e_d[E_VALA +: 64]   = val_a;
      e_d[E_VALB +: 64]   = fwd_b;
      e_d[E_DSTE +: 4]    = dst_e;
      e_d[E_DSTM +: 4]    = dst_m;
      e_d[E_SRCA +: 4]    = src_a;
      e_d[E_SRCB +: 4]    = src_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= E_BUBBLE;
    else        e_q <= e_d;
  end

  assign e_bundle = e_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  localparam logic [144:0] D_BUB = {1'b1, 4'h1, 4'h0, 8'hFF, 128'd0};
  localparam logic [216:0] E_BUB = {1'b1, 4'h1, 4'h0, 192'd0, 16'hFFFF};

  logic         clk;
  logic         rst_n;
  logic [144:0] f_d;
  logic         D_stall, D_bubble, E_bubble;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]   d_srcA, d_srcB;
  logic [216:0] e_bundle;

  int checks = 0;
  int errors = 0;

  logic [144:0] m_d;
  logic [63:0]  m_rf [16];
  logic [216:0] exp_e;

  decode_stage #(.NREG(15), .W(64)) dut (
    .clk(clk), .rst_n(rst_n), .f_d(f_d),
    .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_bundle(e_bundle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [144:0] mk_fd(input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [3:0] ra, input logic [3:0] rb,
                                         input logic [63:0] vc, input logic [63:0] vp);
    return {1'b1, ic, fn, ra, rb, vc, vp};
  endfunction

  function automatic logic [3:0] m_srcA(input logic [144:0] d);
    logic [3:0] ic;
    ic = d[143:140];
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return d[135:132];
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcB(input logic [144:0] d);
    logic [3:0] ic;
    ic = d[143:140];
    if (ic inside {4'h4, 4'h5, 4'h6}) return d[131:128];
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstE(input logic [144:0] d);
    logic [3:0] ic;
    ic = d[143:140];
    if (ic inside {4'h2, 4'h3, 4'h6}) return d[131:128];
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [144:0] d);
    logic [3:0] ic;
    ic = d[143:140];
    if (ic inside {4'h5, 4'hB}) return d[135:132];
    return 4'hF;
  endfunction

  // Priority list of producers scanned in order; first matching ID wins.
  function automatic logic [63:0] m_read(input logic [3:0] s);
    logic [3:0]  dl [5];
    logic [63:0] vl [5];
    dl = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vl = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (s == 4'hF) return 64'd0;
    for (int i = 0; i < 5; i++) if (dl[i] == s) return vl[i];
    return m_rf[s];
  endfunction

  function automatic logic [216:0] m_decode(input logic [144:0] d);
    logic [63:0] va;
    va = (d[143:140] inside {4'h7, 4'h8}) ? d[63:0] : m_read(m_srcA(d));
    return {d[144], d[143:140], d[139:136], d[127:64], va, m_read(m_srcB(d)),
            m_dstE(d), m_dstM(d), m_srcA(d), m_srcB(d)};
  endfunction

  task automatic model_reset();
    m_d = D_BUB;
    exp_e = E_BUB;
    for (int i = 0; i < 16; i++) m_rf[i] = 64'd0;
  endtask

  // Advance model and DUT one clock edge using the inputs currently driven.
  task automatic step();
    exp_e = E_bubble ? E_BUB : m_decode(m_d);
    if (!D_stall) m_d = D_bubble ? D_BUB : f_d;
    if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
    if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [3:0] pick_reg();
    int r;
    r = $urandom_range(0, 6);
    return (r == 6) ? 4'hF : 4'(r);
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle();
    D_stall = 0; D_bubble = 0; E_bubble = 0;
    f_d = D_BUB;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = r64(); M_valE = r64(); m_valM = r64(); W_valE = r64(); W_valM = r64();
  endtask

  task automatic rand_inputs();
    f_d = {1'($urandom), 4'($urandom), 4'($urandom), pick_reg(), pick_reg(), r64(), r64()};
    D_stall  = ($urandom_range(0, 7) == 0);
    D_bubble = ($urandom_range(0, 7) == 0);
    E_bubble = ($urandom_range(0, 7) == 0);
    e_dstE = pick_reg(); M_dstE = pick_reg(); M_dstM = pick_reg();
    W_dstE = pick_reg(); W_dstM = pick_reg();
    e_valE = r64(); M_valE = r64(); m_valM = r64(); W_valE = r64(); W_valM = r64();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (3) begin
      rand_inputs();
      @(posedge clk);
      #1;
    end
    checks++;
    if (e_bundle !== E_BUB) begin
      errors++; $display("FAIL reset_e_bundle got %h want %h", e_bundle, E_BUB);
    end
    checks++;
    if (e_bundle[215:212] !== 4'h1 || e_bundle[15:12] !== 4'hF || e_bundle[143:80] !== 64'd0) begin
      errors++; $display("FAIL reset_fields icode %h dstE %h valA %h want 1 F 0",
                         e_bundle[215:212], e_bundle[15:12], e_bundle[143:80]);
    end
    checks++;
    if (d_srcA !== 4'hF || d_srcB !== 4'hF) begin
      errors++; $display("FAIL reset_srcs got %h %h want F F", d_srcA, d_srcB);
    end
    model_reset();
    idle();
    rst_n = 1;
    // Every register reads 0 after reset.
    for (int r = 0; r < 15; r++) begin
      f_d = mk_fd(4'h6, 4'h0, 4'(r), 4'(14 - r), 64'd0, 64'd0);
      step();
      f_d = D_BUB;
      step();
      checks++;
      if (e_bundle[143:80] !== 64'd0 || e_bundle[79:16] !== 64'd0 || e_bundle !== exp_e) begin
        errors++; $display("FAIL reset_reg%0d valA %h valB %h want 0 0", r,
                           e_bundle[143:80], e_bundle[79:16]);
      end
    end
  endtask

  task automatic test_irmovq();
    idle();
    f_d = mk_fd(4'h3, 4'h0, 4'hF, 4'h2, 64'h1234, 64'h0A);
    step();
    f_d = D_BUB;
    step();
    checks++;
    if (e_bundle[207:144] !== 64'h1234 || e_bundle[15:12] !== 4'h2 ||
        e_bundle[7:4] !== 4'hF || e_bundle[3:0] !== 4'hF) begin
      errors++; $display("FAIL irmovq valC %h dstE %h srcA %h srcB %h want 1234 2 F F",
                         e_bundle[207:144], e_bundle[15:12], e_bundle[7:4], e_bundle[3:0]);
    end
    checks++;
    if (e_bundle !== exp_e) begin
      errors++; $display("FAIL irmovq_model got %h want %h", e_bundle, exp_e);
    end
  endtask

  task automatic test_forward_priority();
    idle();
    f_d = mk_fd(4'h6, 4'h1, 4'h3, 4'h5, 64'd0, 64'd0);
    step();
    checks++;
    if (d_srcA !== 4'h3 || d_srcB !== 4'h5) begin
      errors++; $display("FAIL fwd_srcs got %h %h want 3 5", d_srcA, d_srcB);
    end
    e_dstE = 4'h3; e_valE = 64'hAA;
    W_dstE = 4'h3; W_valE = 64'hBB;
    step();
    checks++;
    if (e_bundle[143:80] !== 64'hAA || e_bundle !== exp_e) begin
      errors++; $display("FAIL fwd_e_over_w valA %h want aa", e_bundle[143:80]);
    end
    e_dstE = 4'hF;
    step();
    checks++;
    if (e_bundle[143:80] !== 64'hBB || e_bundle !== exp_e) begin
      errors++; $display("FAIL fwd_w valA %h want bb", e_bundle[143:80]);
    end
    W_dstE = 4'hF;
    M_dstM = 4'h3; m_valM = 64'hCC;
    M_dstE = 4'h3; M_valE = 64'hDD;
    step();
    checks++;
    if (e_bundle[143:80] !== 64'hCC || e_bundle !== exp_e) begin
      errors++; $display("FAIL fwd_mm_over_me valA %h want cc", e_bundle[143:80]);
    end
  endtask

  task automatic test_write_collision();
    idle();
    W_dstE = 4'h4; W_valE = 64'h10;
    W_dstM = 4'h4; W_valM = 64'h20;
    f_d = mk_fd(4'h6, 4'h0, 4'h4, 4'hF, 64'd0, 64'd0);
    step();
    W_dstE = 4'hF; W_dstM = 4'hF;
    f_d = D_BUB;
    step();
    checks++;
    if (e_bundle[143:80] !== 64'h20 || e_bundle !== exp_e) begin
      errors++; $display("FAIL write_collision reg4 %h want 20", e_bundle[143:80]);
    end
  endtask

  task automatic test_call();
    idle();
    f_d = mk_fd(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40);
    step();
    f_d = D_BUB;
    step();
    checks++;
    if (e_bundle[143:80] !== 64'h40 || e_bundle[3:0] !== 4'h4 ||
        e_bundle[15:12] !== 4'h4 || e_bundle[11:8] !== 4'hF) begin
      errors++; $display("FAIL call valA %h srcB %h dstE %h dstM %h want 40 4 4 F",
                         e_bundle[143:80], e_bundle[3:0], e_bundle[15:12], e_bundle[11:8]);
    end
    checks++;
    if (e_bundle !== exp_e) begin
      errors++; $display("FAIL call_model got %h want %h", e_bundle, exp_e);
    end
  endtask

  task automatic test_control();
    int hits;
    logic [144:0] ia, ib;
    hits = 0;
    idle();
    ia = mk_fd(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h11);
    ib = mk_fd(4'h3, 4'h0, 4'hF, 4'h1, 64'hB2, 64'h22);
    f_d = ia;
    step();
    D_stall = 1; E_bubble = 1;
    for (int c = 0; c < 2; c++) begin
      f_d = mk_fd(4'h3, 4'h0, 4'hF, 4'h6, r64(), r64());
      D_bubble = (c == 1);  // stall must still win
      step();
      if (e_bundle[215:212] === 4'h6 && e_bundle[7:4] === 4'h2) hits++;
      checks++;
      if (e_bundle !== E_BUB || d_srcA !== 4'h2) begin
        errors++; $display("FAIL stall_cycle%0d e %h srcA %h want bubble 2", c, e_bundle, d_srcA);
      end
    end
    D_stall = 0; D_bubble = 0; E_bubble = 0;
    f_d = ib;
    step();
    if (e_bundle[215:212] === 4'h6 && e_bundle[7:4] === 4'h2) hits++;
    checks++;
    if (e_bundle !== exp_e || e_bundle[215:212] !== 4'h6) begin
      errors++; $display("FAIL release_held got %h want %h", e_bundle, exp_e);
    end
    f_d = D_BUB;
    for (int c = 0; c < 2; c++) begin
      step();
      if (e_bundle[215:212] === 4'h6 && e_bundle[7:4] === 4'h2) hits++;
    end
    checks++;
    if (hits != 1) begin
      errors++; $display("FAIL held_once count %0d want 1", hits);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      step();
      checks++;
      if (e_bundle !== exp_e) begin
        errors++; $display("FAIL random_e cycle %0d got %h want %h", n, e_bundle, exp_e);
      end
      checks++;
      if (d_srcA !== m_srcA(m_d) || d_srcB !== m_srcB(m_d)) begin
        errors++; $display("FAIL random_src cycle %0d got %h %h want %h %h", n,
                           d_srcA, d_srcB, m_srcA(m_d), m_srcB(m_d));
      end
      if (n == 200) begin
        // Asynchronous reset pulse mid-cycle discards everything in flight.
        rst_n = 0;
        #1;
        checks++;
        if (e_bundle !== E_BUB || d_srcA !== 4'hF || d_srcB !== 4'hF) begin
          errors++; $display("FAIL async_reset e %h srcA %h srcB %h", e_bundle, d_srcA, d_srcB);
        end
        model_reset();
        #1;
        rst_n = 1;
      end
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    test_reset();
    test_irmovq();
    test_forward_priority();
    test_write_collision();
    test_call();
    test_control();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
